// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED run/pause/step controller.
// Optional button conditioning: LED_CTRL_DEBOUNCE_EN.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_TICK_DIV   = 10000000;
  localparam int DEF_DEB_CYCLES = 500000;

  function automatic int pre_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_counter_ctrl_tick_gen.sv
// Prescaler producing a one-cycle tick every TICK_DIV enabled cycles.
// Optional button conditioning: LED_CTRL_DEBOUNCE_EN.
module tick_gen
  import led_ctrl_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = pre_w(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/led_counter_ctrl.sv
// Run/pause/step sequencer for the prescaled LED counter.
// Define LED_CTRL_DEBOUNCE_EN to condition the push buttons on-chip.
module led_counter_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_pause,
  input  logic             btn_step,
  input  logic             dir,
  input  logic             wrap_en,
  output logic [WIDTH-1:0] led,
  output logic             running,
  output logic             done
);

  logic start_c;
  logic pause_c;
  logic step_c;

`ifdef LED_CTRL_DEBOUNCE_EN
  localparam int CW = pre_w(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CLAST = CW'(DEB_CYCLES - 1);

  logic [2:0] raw;
  logic [2:0] cmd;

  assign raw = {btn_step, btn_pause, btn_start};

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic          s1;
    logic          s2;
    logic          lvl;
    logic          lvl_d;
    logic          pls;
    logic [CW-1:0] cnt;

    // level changes only after DEB_CYCLES samples disagreeing with it
    always_ff @(posedge clk) begin
      if (rst) begin
        s1    <= 1'b0;
        s2    <= 1'b0;
        lvl   <= 1'b0;
        lvl_d <= 1'b0;
        pls   <= 1'b0;
        cnt   <= '0;
      end else begin
        s1    <= raw[i];
        s2    <= s1;
        lvl_d <= lvl;
        pls   <= lvl && !lvl_d;
        if (s2 != lvl) begin
          if (cnt == CLAST) begin
            lvl <= s2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign cmd[i] = pls;
  end

  assign start_c = cmd[0];
  assign pause_c = cmd[1];
  assign step_c  = cmd[2];
`else
  assign start_c = btn_start;
  assign pause_c = btn_pause;
  assign step_c  = btn_step;
`endif

  state_t           state;
  state_t           nxt_state;
  logic [WIDTH-1:0] nxt_led;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] load_val;
  logic             stop;
  logic             tick;
  logic             pre_clr;
  logic             pre_en;

  assign step_val = dir ? led - 1'b1 : led + 1'b1;
  assign term_val = dir ? '0 : '1;
  assign load_val = dir ? '1 : '0;
  assign stop     = (led == term_val) && !wrap_en;

  assign pre_en  = (state == RUN);
  assign pre_clr = (state == IDLE) || (state == DONE)
                || ((state == PAUSE) && start_c && !pause_c);

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_comb begin
    nxt_state = state;
    nxt_led   = led;
    unique case (state)
      IDLE: begin
        if (start_c) begin
          nxt_state = RUN;
          nxt_led   = load_val;
        end
      end
      RUN: begin
        if (tick) begin
          if (stop) nxt_state = DONE;
          else      nxt_led   = step_val;
        end
        // a tick landing on the terminal value beats a same-cycle pause
        if (pause_c && !(tick && stop)) nxt_state = PAUSE;
      end
      PAUSE: begin
        if (step_c) begin
          if (stop) nxt_state = DONE;
          else      nxt_led   = step_val;
        end
        if (start_c && !pause_c) nxt_state = RUN;
      end
      DONE: begin
        if (start_c) begin
          nxt_state = RUN;
          nxt_led   = load_val;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      led     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= nxt_state;
      led     <= nxt_led;
      running <= (nxt_state == RUN);
      done    <= (nxt_state == DONE);
    end
  end

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Directed bench for led_counter_ctrl, WIDTH=4, TICK_DIV=4, DEB_CYCLES=3.
// Build with LED_CTRL_DEBOUNCE_EN to exercise the button filter instead.
module tb_led_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_start;
  logic       btn_pause;
  logic       btn_step;
  logic       dir;
  logic       wrap_en;
  logic [3:0] led;
  logic       running;
  logic       done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  led_counter_ctrl #(
    .WIDTH      (4),
    .TICK_DIV   (4),
    .DEB_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_start (btn_start),
    .btn_pause (btn_pause),
    .btn_step  (btn_step),
    .dir       (dir),
    .wrap_en   (wrap_en),
    .led       (led),
    .running   (running),
    .done      (done)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    btn_start = 1'b0;
    btn_pause = 1'b0;
    btn_step  = 1'b0;
    dir       = 1'b0;
    wrap_en   = 1'b1;
    cyc(2);
    chk("rst_led", 32'(led), 0);
    chk("rst_run", 32'(running), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    cyc(1);

`ifdef LED_CTRL_DEBOUNCE_EN
    // bounce 1,0,1,0,0 then settle high
    btn_start = 1'b1; cyc(1);
    btn_start = 1'b0; cyc(1);
    btn_start = 1'b1; cyc(1);
    btn_start = 1'b0; cyc(2);
    btn_start = 1'b1;
    cyc(6);
    chk("deb_early", 32'(running), 0);
    cyc(1);
    chk("deb_run", 32'(running), 1);
    chk("deb_led0", 32'(led), 0);
    cyc(3);
    btn_start = 1'b0;
    cyc(1);
    chk("deb_led1", 32'(led), 1);
    // clean pause press, held long
    btn_pause = 1'b1;
    cyc(6);
    chk("deb_p_early", 32'(running), 1);
    cyc(1);
    chk("deb_pause", 32'(running), 0);
    cyc(10);
    btn_pause = 1'b0;
    chk("deb_hold", 32'(led), 2);
    cyc(12);
    chk("deb_rel", 32'(running), 0);
`else
    // count up with wrap
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    chk("up_run", 32'(running), 1);
    chk("up_led0", 32'(led), 0);
    cyc(3);
    chk("up_hold0", 32'(led), 0);
    cyc(1);
    chk("up_led1", 32'(led), 1);
    cyc(4);
    chk("up_led2", 32'(led), 2);
    cyc(52);
    chk("up_led15", 32'(led), 15);
    cyc(4);
    chk("up_wrap", 32'(led), 0);
    chk("up_wrap_run", 32'(running), 1);

    // stop at terminal
    cyc(60);
    chk("stop_led15", 32'(led), 15);
    wrap_en = 1'b0;
    cyc(4);
    chk("stop_led", 32'(led), 15);
    chk("stop_done", 32'(done), 1);
    chk("stop_run", 32'(running), 0);
    cyc(8);
    chk("stop_frozen", 32'(led), 15);
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    chk("restart_led", 32'(led), 0);
    chk("restart_run", 32'(running), 1);
    chk("restart_done", 32'(done), 0);
    cyc(3);
    chk("restart_hold", 32'(led), 0);
    cyc(1);
    chk("restart_inc", 32'(led), 1);

    // pause, steps, resume
    wrap_en = 1'b1;
    cyc(16);
    chk("p_led5", 32'(led), 5);
    btn_pause = 1'b1; cyc(1); btn_pause = 1'b0;
    chk("p_run", 32'(running), 0);
    cyc(20);
    chk("p_hold", 32'(led), 5);
    btn_step = 1'b1;
    cyc(1); chk("step6", 32'(led), 6);
    cyc(1); chk("step7", 32'(led), 7);
    cyc(1); chk("step8", 32'(led), 8);
    btn_step = 1'b0;
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    chk("resume_run", 32'(running), 1);
    cyc(3);
    chk("resume_hold", 32'(led), 8);
    cyc(1);
    chk("resume_inc", 32'(led), 9);

    // count down from IDLE, stop at 0
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("dn_rst", 32'(led), 0);
    dir = 1'b1;
    wrap_en = 1'b0;
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    chk("dn_load", 32'(led), 15);
    cyc(4);
    chk("dn_14", 32'(led), 14);
    cyc(56);
    chk("dn_0", 32'(led), 0);
    chk("dn_0_run", 32'(running), 1);
    cyc(4);
    chk("dn_done", 32'(done), 1);
    chk("dn_done_led", 32'(led), 0);

    // simultaneous events
    dir = 1'b0;
    wrap_en = 1'b1;
    btn_start = 1'b1; cyc(1); btn_start = 1'b0;
    chk("sim_start", 32'(led), 0);
    cyc(2);
    btn_start = 1'b1; btn_pause = 1'b1; cyc(1);
    btn_start = 1'b0; btn_pause = 1'b0;
    chk("sp_run", 32'(running), 0);
    chk("sp_done", 32'(done), 0);
    btn_step = 1'b1; cyc(3); btn_step = 1'b0;
    chk("sp_led3", 32'(led), 3);
    btn_step = 1'b1; btn_start = 1'b1; cyc(1);
    btn_step = 1'b0; btn_start = 1'b0;
    chk("ss_led", 32'(led), 4);
    chk("ss_run", 32'(running), 1);
    btn_step = 1'b1; cyc(1); btn_step = 1'b0;
    chk("run_step_ign", 32'(led), 4);
    cyc(2);
    chk("ss_hold", 32'(led), 4);
    cyc(1);
    chk("ss_inc", 32'(led), 5);
    cyc(2);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("mid_rst_led", 32'(led), 0);
    chk("mid_rst_run", 32'(running), 0);
    cyc(8);
    chk("idle_hold", 32'(led), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
